partoserial_tx: RTL and testbench

Transmit-side PHY stage that sits directly upstream of the receive deserializer. It takes 8-bit parallel bytes over a valid/ready handshake and shifts them out serially, MSB first, one bit per clk_8f cycle. When no data is pending it fills the byte slot with the comma/idle character. After reset it sends a fixed comma preamble before accepting data, so the downstream deserializer can lock and go active.

---
 rtl/partoserial_tx.sv | 98 +++++++++
 tb/tb_partoserial_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/partoserial_tx.sv
// Serializer for the TX PHY: bytes in over valid/ready, bits out MSB first on clk_8f.
// After reset a fixed run of comma characters is sent before any data is accepted.
module partoserial_tx #(
    parameter logic [7:0]  COMMA    = 8'hBC,
    parameter int unsigned PREAMBLE = 4
) (
    input  logic       clk_8f,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       byte_strobe,
    output logic       sync_done
);

    typedef enum logic {
        StPreamble,
        StData
    } state_e;

    localparam logic [3:0] PreLast = 4'(PREAMBLE - 1);

    state_e     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] r_hold;
    logic       r_hold_full;
    logic [3:0] r_pre_cnt;
    logic       r_loaded;

    state_e     w_state_next;
    logic [7:0] w_shift_next;
    logic [7:0] w_hold_next;
    logic       w_hold_full_next;
    logic [3:0] w_pre_cnt_next;
    logic       w_load;
    logic       w_accept;

    always_ff @(posedge clk_8f or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= StPreamble;
            r_bit_cnt   <= 3'd7;
            r_shift     <= 8'h00;
            r_hold      <= 8'h00;
            r_hold_full <= 1'b0;
            r_pre_cnt   <= 4'd0;
            r_loaded    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= r_bit_cnt + 3'd1;
            r_shift     <= w_shift_next;
            r_hold      <= w_hold_next;
            r_hold_full <= w_hold_full_next;
            r_pre_cnt   <= w_pre_cnt_next;
            if (w_load) begin
                r_loaded <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = {r_shift[6:0], 1'b0};
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;
        w_pre_cnt_next   = r_pre_cnt;
        w_load           = (r_bit_cnt == 3'd7);
        w_accept         = valid_in && ready_out;

        if (w_load) begin
            if (r_state == StData && r_hold_full) begin
                w_shift_next     = r_hold;
                w_hold_full_next = 1'b0;
            end else begin
                w_shift_next = COMMA;
            end
            if (r_state == StPreamble) begin
                w_pre_cnt_next = r_pre_cnt + 4'd1;
                if (r_pre_cnt == PreLast) begin
                    w_state_next = StData;
                end
            end
        end

        // Accept only happens with hold empty, so it never collides with a drain.
        if (w_accept) begin
            w_hold_next      = data_in;
            w_hold_full_next = 1'b1;
        end
    end

    assign ready_out   = (r_state == StData) && !r_hold_full;
    assign data_out    = r_shift[7];
    assign byte_strobe = (r_bit_cnt == 3'd0) && r_loaded;
    assign sync_done   = (r_state == StData);

endmodule

// File: tb/tb_partoserial_tx.sv
// Bench for partoserial_tx: slot-level reference model checked every cycle, plus
// directed scenarios whose received byte streams are compared with literal values.
module tb_partoserial_tx;

    localparam logic [7:0] COMMA    = 8'hBC;
    localparam int         PREAMBLE = 4;

    logic       clk_8f = 1'b0;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       data_out;
    logic       byte_strobe;
    logic       sync_done;

    int n_checks = 0;
    int n_errors = 0;

    partoserial_tx #(
        .COMMA    (COMMA),
        .PREAMBLE (PREAMBLE)
    ) dut (
        .clk_8f      (clk_8f),
        .reset_L     (reset_L),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .data_out    (data_out),
        .byte_strobe (byte_strobe),
        .sync_done   (sync_done)
    );

    always #5 clk_8f = ~clk_8f;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: slot k (k>=0) starts at edge 8k+1 after release.
    bit         m_on = 1'b0;
    int         m_n;
    logic [7:0] m_cur;
    logic [7:0] m_q[$];

    function automatic logic m_synced();
        return m_n >= 8 * (PREAMBLE - 1) + 1;
    endfunction

    always @(posedge clk_8f or negedge reset_L) begin : model
        logic rdy;
        if (!reset_L) begin
            m_on  = 1'b1;
            m_n   = 0;
            m_cur = 8'h00;
            m_q.delete();
        end else if (m_on) begin
            rdy = m_synced() && (m_q.size() == 0);
            if (m_n % 8 == 0) begin
                if (m_n / 8 >= PREAMBLE && m_q.size() > 0) m_cur = m_q.pop_front();
                else m_cur = COMMA;
            end
            if (valid_in && rdy) m_q.push_back(data_in);
            m_n++;
        end
    end

    function automatic logic [3:0] m_exp();
        int idx;
        if (m_n == 0) return 4'b0000;
        idx = (m_n - 1) % 8;
        return {m_cur[7-idx], idx == 0, m_synced(), m_synced() && (m_q.size() == 0)};
    endfunction

    always @(negedge clk_8f) begin
        if (m_on) chk("cycle", 64'({data_out, byte_strobe, sync_done, ready_out}), 64'(m_exp()));
    end

    // Receive-side deserializer used for the literal slot checks.
    logic [7:0] rx_acc;
    int         rx_bits = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk_8f) begin
        if (!reset_L) begin
            rx_bits = 0;
        end else if (byte_strobe === 1'b1) begin
            rx_acc  = {7'b0, data_out};
            rx_bits = 1;
        end else if (rx_bits > 0 && rx_bits < 8) begin
            rx_acc = {rx_acc[6:0], data_out};
            rx_bits++;
        end
        if (rx_bits == 8) begin
            rx_q.push_back(rx_acc);
            rx_bits = 0;
        end
    end

    task automatic check_rx(input string name, input int n, input logic [63:0] exp);
        chk({name, "_count"}, 64'(rx_q.size()), 64'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            chk(name, 64'(rx_q[i]), 64'(exp[8*(n-1-i) +: 8]));
        end
        rx_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_8f);
    endtask

    // Called exactly at a negedge; releases 2 ns after a later negedge.
    task automatic do_reset();
        #2 reset_L = 1'b0;
        #1 chk("rst_async", 64'({data_out, byte_strobe, sync_done, ready_out}), 64'h0);
        repeat (2) @(negedge clk_8f);
        #2 reset_L = 1'b1;
        rx_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int cnt;
        cnt      = 0;
        valid_in = 1'b1;
        data_in  = b;
        while (ready_out !== 1'b1 && cnt < 100) begin
            @(negedge clk_8f);
            cnt++;
        end
        if (cnt >= 100) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: ready_out=%b after %0d cycles, required 1", ready_out, cnt);
        end
        @(negedge clk_8f);
        valid_in = 1'b0;
    endtask

    initial begin
        reset_L  = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        tick(2);
        do_reset();

        // Idle after reset: comma stream, sync after 4th load edge.
        tick(1);
        chk("first_strobe", 64'({data_out, byte_strobe}), 64'b11);
        tick(23);
        chk("presync", 64'({sync_done, ready_out}), 64'b00);
        tick(1);
        chk("sync_rise", 64'({sync_done, ready_out}), 64'b11);
        tick(39);
        #1 check_rx("idle", 8, 64'hBCBCBCBCBCBCBCBC);
        tick(5);
        chk("mid_comma_bit", 64'(data_out), 64'd1);

        // Mid-byte reset, then valid during preamble is held off.
        do_reset();
        send_byte(8'h11);
        tick(14);
        #1 check_rx("preamble_data", 5, 64'hBCBCBCBC11);

        // Single byte after sync.
        tick(3);
        rx_q.delete();
        send_byte(8'h5A);
        chk("hold_full", 64'(ready_out), 64'd0);
        tick(20);
        #1 check_rx("single", 3, 64'hBC5ABC);

        // Back-to-back stream.
        send_byte(8'h01);
        chk("stream_hold", 64'(ready_out), 64'd0);
        send_byte(8'h02);
        send_byte(8'h03);
        tick(22);
        #1 check_rx("stream", 5, 64'hBC010203BC);

        // Accept on a load edge.
        send_byte(8'hC3);
        tick(15);
        #1 check_rx("load_accept", 2, 64'hBCC3);

        // Reset during bit 3 of an A5 slot.
        send_byte(8'hA5);
        tick(12);
        chk("a5_bit3", 64'({data_out, sync_done, ready_out}), 64'b011);
        tick(0);
        do_reset();
        send_byte(8'h77);
        tick(14);
        #1 check_rx("post_reset", 5, 64'hBCBCBCBC77);

        tick(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
